scan_sequencer: RTL and testbench

Sequential address generator that sits directly upstream of the 3-to-8 one-hot decoder. It drives the decoder's 3-bit select and enable so that enabled channels are activated one at a time in ascending order. Each channel gets a programmable dwell, with an optional blanking gap before it. Typical uses are multiplexed-display digit scanning and round-robin strobe generation.

---
 rtl/scan_sequencer.sv | 165 ++++++++++++++++
 tb/tb_scan_sequencer.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/scan_sequencer.sv
// rtl/scan_sequencer.sv - round-robin channel scanner driving a 3-to-8 decoder
//
// Purpose: steps a registered 3-bit select through the enabled channels of
// chan_mask in ascending order. Each channel gets an optional blanking gap
// with the enable low, followed by a dwell with the enable high.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   start       single-cycle request to begin scanning (ignored while busy)
//   stop        single-cycle abort request (wins over start)
//   chan_mask   per-channel enable, sampled live at launch and at each advance
//   dwell       enable-high cycles per channel (0 acts as 1)
//   blank       enable-low guard cycles before each channel (0 = no gap)
//   sel         registered channel address to the decoder
//   sel_en      registered decoder enable
//   busy        high whenever the sequencer is not idle
//   frame_done  one-cycle pulse when the sweep wraps past the top channel
module scan_sequencer #(
   parameter int DWELL_W = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               stop,
   input  logic [7:0]         chan_mask,
   input  logic [DWELL_W-1:0] dwell,
   input  logic [3:0]         blank,
   output logic [2:0]         sel,
   output logic               sel_en,
   output logic               busy,
   output logic               frame_done
);

   localparam int CNT_W = (DWELL_W > 4) ? DWELL_W : 4;

   typedef enum logic [1:0] {IDLE, BLANK, DWELL} state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [2:0]       sel_nxt;
   logic             sel_en_nxt, busy_nxt, frame_done_nxt;

   logic [2:0]       first_ch;
   logic [2:0]       adv_ch;
   logic             adv_wrap;
   logic             adv_found;
   logic [3:0]       scan_idx;
   logic [CNT_W-1:0] blank_load, dwell_load;
   logic             launch, last_cycle, mask_any;

   // The counter holds remaining cycles minus one, so loading on entry
   // latches the setting for the whole state.
   assign blank_load = CNT_W'(blank) - CNT_W'(1);
   assign dwell_load = (dwell == '0) ? '0 : CNT_W'(dwell) - CNT_W'(1);
   assign mask_any   = |chan_mask;
   assign launch     = start && !stop && mask_any;
   assign last_cycle = (cnt == '0);

   // Channel search: lowest set bit for launch, next set bit above sel for
   // advance. A carry into scan_idx[3] means the search wrapped, which also
   // covers the single-channel case where the only hit is sel itself.
   always_comb begin
      first_ch  = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (chan_mask[i]) first_ch = 3'(i);
      end
      adv_ch    = sel;
      adv_wrap  = 1'b0;
      adv_found = 1'b0;
      scan_idx  = 4'd0;
      for (int k = 1; k <= 8; k++) begin
         scan_idx = {1'b0, sel} + 4'(k);
         if (!adv_found && chan_mask[scan_idx[2:0]]) begin
            adv_found = 1'b1;
            adv_ch    = scan_idx[2:0];
            adv_wrap  = scan_idx[3];
         end
      end
   end

   // State register plus registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cnt        <= '0;
         sel        <= 3'd0;
         sel_en     <= 1'b0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         sel        <= sel_nxt;
         sel_en     <= sel_en_nxt;
         busy       <= busy_nxt;
         frame_done <= frame_done_nxt;
      end
   end

   // Next-state and counter.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         IDLE: begin
            if (launch) begin
               if (blank != 4'd0) begin
                  state_nxt = BLANK;
                  cnt_nxt   = blank_load;
               end else begin
                  state_nxt = DWELL;
                  cnt_nxt   = dwell_load;
               end
            end
         end
         BLANK: begin
            if (stop) begin
               state_nxt = IDLE;
            end else if (last_cycle) begin
               state_nxt = DWELL;
               cnt_nxt   = dwell_load;
            end else begin
               cnt_nxt   = cnt - CNT_W'(1);
            end
         end
         DWELL: begin
            if (stop) begin
               state_nxt = IDLE;
            end else if (last_cycle) begin
               if (!mask_any) begin
                  state_nxt = IDLE;
               end else if (blank != 4'd0) begin
                  state_nxt = BLANK;
                  cnt_nxt   = blank_load;
               end else begin
                  state_nxt = DWELL;
                  cnt_nxt   = dwell_load;
               end
            end else begin
               cnt_nxt   = cnt - CNT_W'(1);
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   // Next values of the registered outputs.
   always_comb begin
      sel_nxt        = sel;
      frame_done_nxt = 1'b0;
      if (state == IDLE && launch) begin
         sel_nxt = first_ch;
      end else if (state == DWELL && !stop && last_cycle && mask_any) begin
         sel_nxt        = adv_ch;
         frame_done_nxt = adv_wrap;
      end
      sel_en_nxt = (state_nxt == DWELL);
      busy_nxt   = (state_nxt != IDLE);
   end

endmodule

// File: tb/tb_scan_sequencer.sv
// tb/tb_scan_sequencer.sv - directed self-checking bench for scan_sequencer
module tb_scan_sequencer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       stop = 1'b0;
   logic [7:0] chan_mask = 8'h00;
   logic [7:0] dwell = 8'd0;
   logic [3:0] blank = 4'd0;
   logic [2:0] sel;
   logic       sel_en;
   logic       busy;
   logic       frame_done;

   int checks = 0;
   int failures = 0;

   scan_sequencer #(.DWELL_W(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .stop       (stop),
      .chan_mask  (chan_mask),
      .dwell      (dwell),
      .blank      (blank),
      .sel        (sel),
      .sel_en     (sel_en),
      .busy       (busy),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   initial begin
      #1ms;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic pulse_stop();
      stop = 1'b1;
      tick();
      stop = 1'b0;
   endtask

   function automatic logic [5:0] out_vec();
      return {sel, sel_en, busy, frame_done};
   endfunction

   // Hand-derived waveforms, t = 0 is the first cycle after the start edge.
   // mode 0: mask FF, dwell 3, blank 1    mode 1: mask A4, dwell 2, blank 2
   // mode 2: mask 81, dwell 0, blank 0    mode 3: mask 10, dwell 3, blank 1
   function automatic logic [5:0] exp_vec(input int mode, input int t);
      logic [2:0] ch;
      logic       en;
      logic       fd;
      case (mode)
         0: begin
            ch = 3'((t / 4) % 8);
            en = (t % 4) != 0;
            fd = (t > 0) && (t % 32 == 0);
         end
         1: begin
            case ((t / 4) % 3)
               0:       ch = 3'd2;
               1:       ch = 3'd5;
               default: ch = 3'd7;
            endcase
            en = (t % 4) >= 2;
            fd = (t > 0) && (t % 12 == 0);
         end
         2: begin
            ch = (t % 2 == 1) ? 3'd7 : 3'd0;
            en = 1'b1;
            fd = (t > 0) && (t % 2 == 0);
         end
         default: begin
            ch = 3'd4;
            en = (t % 4) != 0;
            fd = (t > 0) && (t % 4 == 0);
         end
      endcase
      return {ch, en, 1'b1, fd};
   endfunction

   task automatic run_mode(input int mode, input int last_t);
      for (int t = 0; t <= last_t; t++) begin
         check_eq($sformatf("m%0d_t%0d", mode, t), 32'(out_vec()), 32'(exp_vec(mode, t)));
         if (t < last_t) tick();
      end
   endtask

   initial begin
      // Reset state
      #12;
      check_eq("reset_vec", 32'(out_vec()), 32'd0);
      rst_n = 1'b1;
      tick();
      check_eq("idle_vec", 32'(out_vec()), 32'd0);

      // Start with empty mask is ignored
      chan_mask = 8'h00; dwell = 8'd3; blank = 4'd1;
      pulse_start();
      check_eq("mask0_busy", 32'(busy), 32'd0);
      tick();
      check_eq("mask0_vec", 32'(out_vec()), 32'd0);

      // Start and stop together: stop wins
      chan_mask = 8'hFF;
      start = 1'b1; stop = 1'b1;
      tick();
      start = 1'b0; stop = 1'b0;
      check_eq("collide_busy", 32'(busy), 32'd0);

      // Full sweep then stop during blank of channel 0
      pulse_start();
      run_mode(0, 32);
      pulse_stop();
      check_eq("stop_full", 32'(out_vec()), 32'({3'd0, 3'b000}));

      // Sparse mask
      chan_mask = 8'hA4; dwell = 8'd2; blank = 4'd2;
      pulse_start();
      run_mode(1, 24);
      pulse_stop();
      check_eq("stop_sparse", 32'(out_vec()), 32'({3'd2, 3'b000}));

      // Zero dwell and blank
      chan_mask = 8'h81; dwell = 8'd0; blank = 4'd0;
      pulse_start();
      run_mode(2, 8);
      pulse_stop();
      check_eq("stop_zero", 32'({sel_en, busy}), 32'd0);

      // Stop mid-dwell on channel 3
      chan_mask = 8'hFF; dwell = 8'd3; blank = 4'd1;
      pulse_start();
      run_mode(0, 14);
      pulse_stop();
      check_eq("stop_ch3", 32'(out_vec()), 32'({3'd3, 3'b000}));
      tick();
      check_eq("stop_ch3_hold", 32'(out_vec()), 32'({3'd3, 3'b000}));

      // Single channel, then mask cleared during its dwell
      chan_mask = 8'h10;
      pulse_start();
      run_mode(3, 13);
      chan_mask = 8'h00;
      tick();
      check_eq("clr_t14", 32'(out_vec()), 32'({3'd4, 3'b110}));
      tick();
      check_eq("clr_t15", 32'(out_vec()), 32'({3'd4, 3'b110}));
      tick();
      check_eq("clr_idle", 32'(out_vec()), 32'({3'd4, 3'b000}));

      // Asynchronous reset in the middle of a dwell on channel 1
      chan_mask = 8'hFF; dwell = 8'd3; blank = 4'd1;
      pulse_start();
      run_mode(0, 5);
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("async_rst", 32'(out_vec()), 32'd0);
      #3;
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      check_eq("post_rst_idle", 32'(out_vec()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
